// File: rtl/dreg_pipe.sv
// DEPTH-stage WIDTH-bit register pipeline with valid/ready handshakes, bubble collapse, enable and flush.
// Latency is DEPTH cycles. in_ready is a combinational ready chain, so a full pipeline still accepts when the tail drains.
module dreg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            v_nxt;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            ld;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] d_nxt;
    logic [OW-1:0]               occ_nxt;
    logic                        act;

    assign act = en & ~flush;

    // A stage advances when it holds data and the stage ahead is empty or emptying.
    always_comb begin : adv_chain
        logic c;
        c = act & v[DEPTH-1] & out_ready;
        adv = '0;
        adv[DEPTH-1] = c;
        for (int i = DEPTH-2; i >= 0; i--) begin
            c = act & v[i] & (~v[i+1] | c);
            adv[i] = c;
        end
    end

    assign in_ready  = reset & act & (~v[0] | adv[0]);
    assign out_valid = act & v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        ld    = '0;
        ld[0] = in_valid & in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            ld[i] = adv[i-1];
        end
    end

    always_comb begin
        v_nxt = v;
        d_nxt = d;
        if (en && flush) begin
            v_nxt = '0;
        end else if (act) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_nxt[i] = ld[i] | (v[i] & ~adv[i]);
            end
        end
        // Data is only written on load; empty stages keep stale data.
        if (ld[0]) begin
            d_nxt[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (ld[i]) begin
                d_nxt[i] = d[i-1];
            end
        end
    end

    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + OW'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            d         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            d         <= d_nxt;
            occupancy <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_dreg_pipe.sv
// Bench for dreg_pipe (WIDTH=8, DEPTH=4): vector table, scoreboard and hand-written corner sequences.
module tb_dreg_pipe;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit lat_chk = 0;

    typedef struct {
        logic [7:0] dat;
        int         acc_edge;
    } sb_t;
    sb_t q[$];

    typedef struct {
        logic       en;
        logic       flush;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [2:0] occ;
    } vec_t;
    vec_t tbl[$];

    dreg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic rchk(input string nm);
        chk({nm, ".out_valid"}, out_valid, 0);
        chk({nm, ".out_data"},  out_data,  0);
        chk({nm, ".occupancy"}, occupancy, 0);
        chk({nm, ".in_ready"},  in_ready,  0);
    endtask

    // Drive one cycle, sample between edges, and update the scoreboard for the coming edge.
    task automatic do_cycle(input logic e, input logic f, input logic iv, input logic [7:0] id,
                            input logic ordy, output logic ir, output logic ov,
                            output logic [7:0] od, output logic [2:0] oc);
        sb_t s;
        en = e; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        ir = in_ready; ov = out_valid; od = out_data; oc = occupancy;
        chk("sb_occ", occupancy, q.size());
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no output", out_data);
            end else begin
                s = q.pop_front();
                chk("sb_data", out_data, s.dat);
                if (lat_chk) chk("sb_latency", cyc + 1 - s.acc_edge, D);
            end
        end
        if (in_valid && in_ready) begin
            s.dat = in_data;
            s.acc_edge = cyc + 1;
            q.push_back(s);
        end
        if (en && flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic ordy);
        logic ir, ov;
        logic [7:0] od;
        logic [2:0] oc;
        ir = 1'b0;
        for (int k = 0; k < 20 && !ir; k++) do_cycle(1, 0, 1, w, ordy, ir, ov, od, oc);
        chk("send_accept", ir, 1);
    endtask

    task automatic drain();
        logic ir, ov;
        logic [7:0] od;
        logic [2:0] oc;
        for (int k = 0; k < 30 && q.size() != 0; k++) do_cycle(1, 0, 0, 8'h00, 1, ir, ov, od, oc);
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic vec_t mk(input logic e, input logic f, input logic iv, input logic [7:0] id,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [7:0] od, input logic [2:0] occ);
        vec_t t;
        t.en = e; t.flush = f; t.iv = iv; t.id = id; t.ordy = ordy;
        t.ir = ir; t.ov = ov; t.od = od; t.occ = occ;
        return t;
    endfunction

    initial begin
        logic ir, ov;
        logic [7:0] od;
        logic [2:0] oc;

        // Fill under stall, then release.
        tbl.push_back(mk(1,0,1,8'hA1,0, 1,0,8'h00,0));
        tbl.push_back(mk(1,0,1,8'hA2,0, 1,0,8'h00,1));
        tbl.push_back(mk(1,0,1,8'hA3,0, 1,0,8'h00,2));
        tbl.push_back(mk(1,0,1,8'hA4,0, 1,0,8'h00,3));
        tbl.push_back(mk(1,0,1,8'hA5,0, 0,1,8'hA1,4));
        tbl.push_back(mk(1,0,1,8'hA5,0, 0,1,8'hA1,4));
        tbl.push_back(mk(1,0,1,8'hA5,1, 1,1,8'hA1,4));
        tbl.push_back(mk(1,0,1,8'hA6,1, 1,1,8'hA2,4));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA3,4));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA4,3));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA5,2));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hA6,1));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0));
        // Enable freeze with two words in flight.
        tbl.push_back(mk(1,0,1,8'hB1,0, 1,0,8'h00,0));
        tbl.push_back(mk(1,0,1,8'hB2,0, 1,0,8'h00,1));
        tbl.push_back(mk(0,0,1,8'hB3,1, 0,0,8'h00,2));
        tbl.push_back(mk(0,0,1,8'hB3,1, 0,0,8'h00,2));
        tbl.push_back(mk(0,0,1,8'hB3,1, 0,0,8'h00,2));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,2));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,2));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hB1,2));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,8'hB2,1));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0));
        // Flush with three words in flight and a competing input.
        tbl.push_back(mk(1,0,1,8'hC1,0, 1,0,8'h00,0));
        tbl.push_back(mk(1,0,1,8'hC2,0, 1,0,8'h00,1));
        tbl.push_back(mk(1,0,1,8'hC3,0, 1,0,8'h00,2));
        tbl.push_back(mk(1,1,1,8'h55,1, 0,0,8'h00,3));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1,0,0,8'h00,1, 1,0,8'h00,0));

        // Reset state, applied by an explicit falling edge.
        reset = 1; en = 1; flush = 0; in_valid = 1; in_data = 8'hFF; out_ready = 1;
        #1 reset = 0;
        #2 rchk("rst_init");
        repeat (2) @(posedge clk);
        #3 rchk("rst_hold");
        in_valid = 0;
        @(negedge clk) reset = 1;
        @(posedge clk);
        #1;

        // Back-to-back stream with latency checking.
        lat_chk = 1;
        for (int i = 0; i < 20; i++) begin
            send(8'(i), 1);
            if (i == 10) chk("stream_occ", occupancy, 4);
        end
        drain();
        lat_chk = 0;

        // Bubble collapse.
        do_cycle(1, 0, 1, 8'h11, 0, ir, ov, od, oc);
        repeat (2) do_cycle(1, 0, 0, 8'h00, 0, ir, ov, od, oc);
        do_cycle(1, 0, 1, 8'h22, 0, ir, ov, od, oc);
        chk("bub_acc", ir, 1);
        repeat (3) do_cycle(1, 0, 0, 8'h00, 0, ir, ov, od, oc);
        chk("bub_v", dut.v, 4'b1100);
        chk("bub_occ", occupancy, 2);
        do_cycle(1, 0, 0, 8'h00, 1, ir, ov, od, oc);
        chk("bub_ov0", ov, 1);
        chk("bub_d0", od, 8'h11);
        do_cycle(1, 0, 0, 8'h00, 1, ir, ov, od, oc);
        chk("bub_ov1", ov, 1);
        chk("bub_d1", od, 8'h22);
        do_cycle(1, 0, 0, 8'h00, 1, ir, ov, od, oc);
        chk("bub_ov2", ov, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(tbl[i].en, tbl[i].flush, tbl[i].iv, tbl[i].id, tbl[i].ordy, ir, ov, od, oc);
            chk($sformatf("tbl[%0d].in_ready", i), ir, tbl[i].ir);
            chk($sformatf("tbl[%0d].out_valid", i), ov, tbl[i].ov);
            chk($sformatf("tbl[%0d].occupancy", i), oc, tbl[i].occ);
            if (tbl[i].ov) chk($sformatf("tbl[%0d].out_data", i), od, tbl[i].od);
        end

        // Fill, freeze while full, then asynchronous reset between edges.
        send(8'hD1, 0);
        send(8'hD2, 0);
        send(8'hD3, 0);
        send(8'hD4, 0);
        do_cycle(0, 0, 1, 8'hD5, 1, ir, ov, od, oc);
        chk("full_frz_ir", ir, 0);
        chk("full_frz_ov", ov, 0);
        chk("full_frz_occ", oc, 4);
        do_cycle(1, 0, 0, 8'h00, 0, ir, ov, od, oc);
        chk("full_ir", ir, 0);
        chk("full_ov", ov, 1);
        chk("full_d", od, 8'hD1);
        out_ready = 1; in_valid = 1; in_data = 8'hE0;
        reset = 0;
        #2 rchk("rst_mid");
        q.delete();
        in_valid = 0;
        @(negedge clk) reset = 1;
        @(posedge clk);
        #1;
        repeat (2) begin
            do_cycle(1, 0, 0, 8'h00, 1, ir, ov, od, oc);
            chk("post_rst_occ", oc, 0);
            chk("post_rst_ov", ov, 0);
        end
        lat_chk = 1;
        send(8'hE1, 1);
        drain();
        lat_chk = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
